// File: rtl/hazard_pkg.sv
// hazard_pkg: shared hazard-control types, default latencies and the forward-select helper.
package hazard_pkg;
   localparam int MUL_LAT_DEF = 3;
   localparam int DIV_LAT_DEF = 34;

   typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2} fwd_sel_t;
   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
   typedef enum logic {F_IDLE, F_DROP} fetch_state_t;

   // MEM wins over WB because it holds the younger value
   function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
      return mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);
   endfunction
endpackage

// File: rtl/pipes_pkg.sv
// pipes: per-pipeline-register enable vectors (fd, de, em, mw; fd is the MSB).
package pipes;
   typedef struct packed {
      logic fd;
      logic de;
      logic em;
      logic mw;
   } regstall_en_t;

   typedef struct packed {
      logic fd;
      logic de;
      logic em;
      logic mw;
   } regflush_en_t;
endpackage

// File: rtl/hazard_ctrl_md_ctr.sv
// hazard_md_ctr: mul/div EX-occupancy FSM; stalls for LAT cycles, then waits in MD_DONE for EX to advance.
module hazard_md_ctr
   import hazard_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic md_start_i,
   input  logic md_is_div_i,
   input  logic em_adv_i,
   output logic md_stall_o,
   output logic md_busy_o
);
   localparam int CW = $clog2(DIV_LAT > MUL_LAT ? DIV_LAT : MUL_LAT);

   md_state_t st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         st_q  <= MD_IDLE;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      st_d       = st_q;
      cnt_d      = cnt_q;
      md_stall_o = 1'b0;
      case (st_q)
         MD_IDLE: if (md_start_i) begin
            md_stall_o = 1'b1;
            cnt_d      = md_is_div_i ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
            st_d       = MD_BUSY;
         end
         MD_BUSY: begin
            md_stall_o = 1'b1;
            cnt_d      = cnt_q - CW'(1);
            st_d       = (cnt_q == CW'(1)) ? MD_DONE : MD_BUSY;
         end
         MD_DONE: st_d = em_adv_i ? MD_IDLE : MD_DONE;
         default: st_d = MD_IDLE;
      endcase
   end

   assign md_busy_o = st_q != MD_IDLE;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush/forward control with mul/div and fetch-drop FSMs.
// Define HAZARD_FWD_EN to enable EX operand forwarding; otherwise EX/MEM dependences stall.
module hazard_ctrl
   import hazard_pkg::*;
   import pipes::*;
#(
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              ireq_busy_i,
   input  logic              idata_ok_i,
   input  logic              d_wait_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic [1:0]        id_rs_used_i,
   input  logic [REG_AW-1:0] ex_rs1_i,
   input  logic [REG_AW-1:0] ex_rs2_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              ex_wen_i,
   input  logic              ex_is_load_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   input  logic              mem_wen_i,
   input  logic              mem_is_load_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic              wb_wen_i,
   input  logic              md_start_i,
   input  logic              md_is_div_i,
   input  logic              redirect_i,
   output logic              pc_hold_o,
   output regstall_en_t      stall_o,
   output regflush_en_t      flush_o,
   output fwd_sel_t          fwd_a_o,
   output fwd_sel_t          fwd_b_o,
   output logic              md_busy_o
);
   fetch_state_t f_q, f_d;
   logic ex_v, mem_v, ex_hit, load_use, fetch_wait, drop_hit, md_stall, em_adv;

   assign ex_v   = ex_wen_i && ex_rd_i != '0;
   assign mem_v  = mem_wen_i && mem_rd_i != '0;
   assign ex_hit = (id_rs_used_i[0] && id_rs1_i == ex_rd_i) || (id_rs_used_i[1] && id_rs2_i == ex_rd_i);

`ifdef HAZARD_FWD_EN
   logic wb_v;
   assign wb_v     = wb_wen_i && wb_rd_i != '0;
   assign load_use = ex_v && ex_is_load_i && ex_hit;
   // a load still in MEM has no data yet, so it is never a forward source
   assign fwd_a_o  = fwd_pick(mem_v && !mem_is_load_i && mem_rd_i == ex_rs1_i, wb_v && wb_rd_i == ex_rs1_i);
   assign fwd_b_o  = fwd_pick(mem_v && !mem_is_load_i && mem_rd_i == ex_rs2_i, wb_v && wb_rd_i == ex_rs2_i);
`else
   logic mem_hit, unused_fwd;
   assign mem_hit    = (id_rs_used_i[0] && id_rs1_i == mem_rd_i) || (id_rs_used_i[1] && id_rs2_i == mem_rd_i);
   assign load_use   = (ex_v && ex_hit) || (mem_v && mem_hit);
   assign fwd_a_o    = FWD_RF;
   assign fwd_b_o    = FWD_RF;
   assign unused_fwd = ^{ex_rs1_i, ex_rs2_i, ex_is_load_i, mem_is_load_i, wb_rd_i, wb_wen_i};
`endif

   assign em_adv = !(d_wait_i || md_stall);

   hazard_md_ctr #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_md (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .md_start_i (md_start_i),
      .md_is_div_i(md_is_div_i),
      .em_adv_i   (em_adv),
      .md_stall_o (md_stall),
      .md_busy_o  (md_busy_o)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) f_q <= F_IDLE;
      else         f_q <= f_d;
   end

   always_comb begin
      f_d = f_q;
      if (f_q == F_IDLE) f_d = (redirect_i && ireq_busy_i && !idata_ok_i) ? F_DROP : F_IDLE;
      else               f_d = idata_ok_i ? F_IDLE : F_DROP;
   end

   assign fetch_wait = ireq_busy_i || (f_q == F_DROP && !idata_ok_i);
   assign drop_hit   = f_q == F_DROP && idata_ok_i;

   always_comb begin
      pc_hold_o = 1'b0;
      stall_o   = '0;
      flush_o   = '0;
      if (d_wait_i) begin
         pc_hold_o = 1'b1;
         stall_o   = '1;
      end else if (md_stall) begin
         pc_hold_o  = 1'b1;
         stall_o.fd = 1'b1;
         stall_o.de = 1'b1;
         stall_o.em = 1'b1;
         flush_o.mw = 1'b1;
      end else if (redirect_i) begin
         flush_o.fd = 1'b1;
         flush_o.de = 1'b1;
      end else if (load_use) begin
         pc_hold_o  = 1'b1;
         stall_o.fd = 1'b1;
         stall_o.de = 1'b1;
         flush_o.em = 1'b1;
      end else if (fetch_wait || drop_hit) begin
         pc_hold_o  = fetch_wait;
         flush_o.fd = 1'b1;
      end
   end
endmodule
